// File: rtl/aes_pkg.sv
// Shared AES definitions: block/word geometry, serializer state type and a word-select helper.
package aes_pkg;
   localparam int AES_BLK_W  = 128;
   localparam int AES_WORD_W = 32;
   localparam int AES_NWORDS = 4;

   typedef logic [AES_BLK_W-1:0]  aes_blk_t;
   typedef logic [AES_WORD_W-1:0] aes_word_t;
   typedef enum logic {SER_IDLE, SER_SEND} ser_state_t;

   // Word 0 is the most significant 32 bits of the block.
   function automatic aes_word_t blk_word(input aes_blk_t blk, input logic [1:0] idx);
      aes_word_t w;
      case (idx)
         2'd0:    w = blk[127:96];
         2'd1:    w = blk[95:64];
         2'd2:    w = blk[63:32];
         default: w = blk[31:0];
      endcase
      return w;
   endfunction
endpackage

// File: rtl/aes_blk_fifo.sv
// DEPTH x 128-bit block FIFO; a write into a full FIFO succeeds when a read frees the head slot that cycle.
module aes_blk_fifo
   import aes_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en_i,
   input  aes_blk_t                   wr_data_i,
   input  logic                       rd_en_i,
   output aes_blk_t                   head_o,
   output logic [$clog2(DEPTH):0]     level_o,
   output logic                       full_o,
   output logic                       empty_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [LW-1:0] level_q;
   aes_blk_t      mem_q [DEPTH];
   logic          wr_ok, rd_ok;

   assign full_o  = (level_q == LW'(DEPTH));
   assign empty_o = (level_q == '0);
   assign rd_ok   = rd_en_i & ~empty_o;
   assign wr_ok   = wr_en_i & (~full_o | rd_ok);
   assign head_o  = mem_q[rd_ptr_q];
   assign level_o = level_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (wr_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (rd_ok) rd_ptr_q <= rd_ptr_q + PW'(1);
         level_q <= level_q + LW'(wr_ok) - LW'(rd_ok);
      end
   end

   // Storage needs no reset: nothing is visible until level says so.
   always_ff @(posedge clk) begin
      if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
   end
endmodule

// File: rtl/aes_out_serializer.sv
// Buffers AES output blocks on done and streams each as four 32-bit words over valid/ready.
module aes_out_serializer
   import aes_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       done,
   input  logic [AES_BLK_W-1:0]       text_out,
   output logic [AES_WORD_W-1:0]      out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       out_last,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       ovf,
   input  logic                       clr_ovf
);
   localparam int LW = $clog2(DEPTH) + 1;

   ser_state_t    state_q;
   logic [1:0]    cnt_q;
   logic          ovf_q;
   aes_blk_t      head;
   logic          full, empty;
   logic          pop, capture;
   logic [LW-1:0] level_d;

   aes_blk_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (done),
      .wr_data_i (text_out),
      .rd_en_i   (pop),
      .head_o    (head),
      .level_o   (level),
      .full_o    (full),
      .empty_o   (empty)
   );

   assign out_valid = (state_q == SER_SEND);
   assign pop       = out_valid & out_ready & (cnt_q == 2'd3);
   assign capture   = done & (~full | pop);
   assign level_d   = level + LW'(capture) - LW'(pop);
   assign out_data  = out_valid ? blk_word(head, cnt_q) : '0;
   assign out_last  = out_valid & (cnt_q == 2'd3);
   assign ovf       = ovf_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= SER_IDLE;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         // A fresh drop wins over a simultaneous clear.
         ovf_q <= (ovf_q & ~clr_ovf) | (done & full & ~pop);
         case (state_q)
            SER_IDLE: begin
               if (!empty || capture) state_q <= SER_SEND;
            end
            SER_SEND: begin
               if (out_ready) begin
                  cnt_q <= cnt_q + 2'd1;
                  if (cnt_q == 2'd3 && level_d == '0) state_q <= SER_IDLE;
               end
            end
            default: state_q <= SER_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_aes_out_serializer.sv
// Scoreboard bench: stimulus queues expected words, a negedge monitor checks every transfer.
module tb_aes_out_serializer;
   import aes_pkg::*;

   typedef struct packed {
      logic [31:0] data;
      logic        last;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         done;
   logic [127:0] text_out;
   logic [31:0]  out_data;
   logic         out_valid;
   logic         out_ready;
   logic         out_last;
   logic [1:0]   level;
   logic         ovf;
   logic         clr_ovf;

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t sb_q[$];

   localparam logic [127:0] B1 = 128'h00112233_44556677_8899aabb_ccddeeff;
   localparam logic [127:0] B2 = 128'hdeadbeef_01020304_a5a5a5a5_5a5a5a5a;
   localparam logic [127:0] B3 = 128'hcafef00d_11111111_22222222_33333333;
   localparam logic [127:0] B4 = 128'h0badc0de_feedface_12345678_9abcdef0;

   aes_out_serializer #(.DEPTH(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .done      (done),
      .text_out  (text_out),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .level     (level),
      .ovf       (ovf),
      .clr_ovf   (clr_ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_blk(input logic [127:0] b);
      sb_q.push_back('{data: b[127:96], last: 1'b0});
      sb_q.push_back('{data: b[95:64],  last: 1'b0});
      sb_q.push_back('{data: b[63:32],  last: 1'b0});
      sb_q.push_back('{data: b[31:0],   last: 1'b1});
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (sb_q.size() != 0 && n < 100) begin
         tick();
         n++;
      end
      check({name, "_drain_timeout"}, 32'(sb_q.size()), 32'd0);
   endtask

   // Monitor: every transfer is popped and compared; stalled outputs must hold.
   logic        p_valid = 1'b0, p_ready = 1'b0, p_last = 1'b0;
   logic [31:0] p_data = '0;
   always @(negedge clk) begin
      if (!rst) begin
         p_valid = 1'b0;
      end else begin
         if (p_valid && !p_ready) begin
            check("stall_valid_held", {31'd0, out_valid}, 32'd1);
            check("stall_data_held", out_data, p_data);
            check("stall_last_held", {31'd0, out_last}, {31'd0, p_last});
         end
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               check("unexpected_word", out_data, 32'hxxxxxxxx);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               check("word_data", out_data, e.data);
               check("word_last", {31'd0, out_last}, {31'd0, e.last});
            end
         end
         p_valid = out_valid;
         p_ready = out_ready;
         p_data  = out_data;
         p_last  = out_last;
      end
   end

   initial begin
      int pat[4] = '{1, 0, 0, 1};
      int gaps;
      int n;
      rst = 1'b0; done = 1'b0; text_out = '0; out_ready = 1'b0; clr_ovf = 1'b0;

      // Reset state and done ignored during reset
      repeat (3) tick();
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_level", {30'd0, level}, 32'd0);
      check("rst_ovf", {31'd0, ovf}, 32'd0);
      check("rst_data", out_data, 32'd0);
      done = 1'b1; text_out = B4;
      tick();
      done = 1'b0;
      check("rst_done_ignored", {30'd0, level}, 32'd0);
      rst = 1'b1;
      tick(); tick();
      check("post_rst_valid", {31'd0, out_valid}, 32'd0);

      // Single block, one-cycle latency
      out_ready = 1'b1;
      done = 1'b1; text_out = B1; push_blk(B1);
      tick();
      done = 1'b0;
      check("lat_valid", {31'd0, out_valid}, 32'd1);
      check("lat_word0", out_data, 32'h00112233);
      check("single_level", {30'd0, level}, 32'd1);
      drain("single");
      check("single_level_end", {30'd0, level}, 32'd0);
      check("single_idle", {31'd0, out_valid}, 32'd0);

      // Backpressure pattern 1,0,0,1
      done = 1'b1; text_out = B1; push_blk(B1);
      n = 0;
      while ((n == 0 || sb_q.size() != 0) && n < 60) begin
         out_ready = pat[n % 4][0];
         tick();
         done = 1'b0;
         n++;
      end
      check("bp_drain_timeout", 32'(sb_q.size()), 32'd0);
      out_ready = 1'b1;
      tick();
      check("bp_level_end", {30'd0, level}, 32'd0);

      // Back-to-back: two dones 2 cycles apart
      done = 1'b1; text_out = B2; push_blk(B2);
      tick();
      done = 1'b0;
      tick();
      done = 1'b1; text_out = B3; push_blk(B3);
      tick();
      done = 1'b0;
      check("b2b_level_peak", {30'd0, level}, 32'd2);
      gaps = 0; n = 0;
      while (sb_q.size() != 0 && n < 40) begin
         if (!out_valid) gaps++;
         tick();
         n++;
      end
      check("b2b_gaps", 32'(gaps), 32'd0);
      check("b2b_drain_timeout", 32'(sb_q.size()), 32'd0);
      check("b2b_level_end", {30'd0, level}, 32'd0);

      // Overflow: third block dropped, stored blocks untouched
      out_ready = 1'b0;
      done = 1'b1; text_out = B1; push_blk(B1);
      tick();
      text_out = B2; push_blk(B2);
      tick();
      text_out = B3;
      tick();
      done = 1'b0;
      check("ovf_set", {31'd0, ovf}, 32'd1);
      check("ovf_level", {30'd0, level}, 32'd2);
      check("ovf_head_word0", out_data, 32'h00112233);
      out_ready = 1'b1;
      drain("ovf");
      check("ovf_sticky", {31'd0, ovf}, 32'd1);
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      check("ovf_cleared", {31'd0, ovf}, 32'd0);

      // Full with done on the word3 transfer
      out_ready = 1'b0;
      done = 1'b1; text_out = B2; push_blk(B2);
      tick();
      text_out = B3; push_blk(B3);
      tick();
      done = 1'b0;
      check("full_level", {30'd0, level}, 32'd2);
      out_ready = 1'b1;
      tick(); tick(); tick();
      check("full_last_ready", {31'd0, out_last}, 32'd1);
      done = 1'b1; text_out = B4; push_blk(B4);
      tick();
      done = 1'b0;
      check("full_pop_level", {30'd0, level}, 32'd2);
      check("full_pop_ovf", {31'd0, ovf}, 32'd0);
      drain("fullpop");
      check("fullpop_level_end", {30'd0, level}, 32'd0);

      // Mid-stream reset after word1
      done = 1'b1; text_out = B1; push_blk(B1);
      tick();
      done = 1'b0;
      tick(); tick();
      rst = 1'b0;
      #1;
      check("midrst_valid", {31'd0, out_valid}, 32'd0);
      check("midrst_level", {30'd0, level}, 32'd0);
      check("midrst_words_left", 32'(sb_q.size()), 32'd2);
      sb_q.delete();
      tick(); tick();
      rst = 1'b1;
      gaps = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (out_valid) gaps++;
      end
      check("midrst_no_stale", 32'(gaps), 32'd0);
      check("midrst_level_after", {30'd0, level}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
